// File: rtl/bit_fifo_if.sv
// Handshake/bus bundle for bit_fifo; ovf/udf exist only when BIT_FIFO_ERR_EN is defined.
interface bit_fifo_if #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WR_W  = 8,
  parameter int unsigned RD_W  = 3
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            wr;
  logic [WR_W-1:0] DB;
  logic            bit4;
  logic            out_en;
  logic [RD_W-1:0] out;
  logic            out_vld;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
`ifdef BIT_FIFO_ERR_EN
  logic            ovf;
  logic            udf;
`endif

  modport master (
    output wr, DB, bit4, out_en,
    input  out, out_vld, count, full, empty
`ifdef BIT_FIFO_ERR_EN
    , input ovf, udf
`endif
  );

  modport slave (
    input  wr, DB, bit4, out_en,
    output out, out_vld, count, full, empty
`ifdef BIT_FIFO_ERR_EN
    , output ovf, udf
`endif
  );
endinterface

// File: rtl/bit_fifo.sv
// Circular bit buffer: WR_W (or WR_W/2) bits in, RD_W bits out per request.
// Define BIT_FIFO_ERR_EN to add sticky ovf/udf flags for rejected requests.
module bit_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WR_W  = 8,
  parameter int unsigned RD_W  = 3
) (
  input  logic      Clk,
  input  logic      Rst,
  bit_fifo_if.slave bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned HALF_W = WR_W / 2;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    free_c;
  logic [CW-1:0]    wr_n_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic [RD_W-1:0]  rd_word_c;
  logic [RD_W-1:0]  out_q;
  logic             out_vld_q;

  // Both requests are judged against the pre-edge count, so a read never frees room for a same-cycle write.
  always_comb begin
    wr_n_c   = bus.bit4 ? CW'(HALF_W) : CW'(WR_W);
    free_c   = CW'(DEPTH) - count_q;
    wr_acc_c = bus.wr && (free_c >= wr_n_c);
    rd_acc_c = bus.out_en && (count_q >= CW'(RD_W));
  end

  // Read word gathers RD_W bits starting at rp; pointer arithmetic wraps naturally at DEPTH.
  always_comb begin
    rd_word_c = '0;
    for (int k = 0; k < int'(RD_W); k++) begin
      rd_word_c[k] = mem[AW'(rp + AW'(k))];
    end
  end

  // Storage is never cleared; stale bits stay unreachable behind the pointers.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_acc_c) begin
      for (int k = 0; k < int'(WR_W); k++) begin
        if (CW'(k) < wr_n_c) begin
          mem[AW'(wp + AW'(k))] <= bus.DB[k];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wp        <= '0;
      rp        <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wp <= wp + AW'(wr_n_c);
      end
      if (rd_acc_c) begin
        rp    <= rp + AW'(RD_W);
        out_q <= rd_word_c;
      end
      out_vld_q <= rd_acc_c;
      count_q   <= count_q + (wr_acc_c ? wr_n_c : CW'(0)) - (rd_acc_c ? CW'(RD_W) : CW'(0));
    end
  end

`ifdef BIT_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr && !wr_acc_c) begin
        ovf_q <= 1'b1;
      end
      if (bus.out_en && !rd_acc_c) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif

  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.count   = count_q;
  assign bus.full    = (free_c < CW'(WR_W));
  assign bus.empty   = (count_q < CW'(RD_W));
endmodule

// File: tb/tb_bit_fifo.sv
// Directed bench for bit_fifo with DEPTH=512, WR_W=8, RD_W=3.
module tb_bit_fifo;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned WR_W  = 8;
  localparam int unsigned RD_W  = 3;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  bit_fifo_if #(.DEPTH(DEPTH), .WR_W(WR_W), .RD_W(RD_W)) bif ();

  bit_fifo #(.DEPTH(DEPTH), .WR_W(WR_W), .RD_W(RD_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bif)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request; outputs settle and are sampled 1ns after the edge.
  task automatic op(input logic w, input logic [7:0] d, input logic b4, input logic re, input logic rst);
    bif.wr     = w;
    bif.DB     = d;
    bif.bit4   = b4;
    bif.out_en = re;
    Rst        = rst;
    @(posedge Clk);
    #1;
    bif.wr     = 1'b0;
    bif.out_en = 1'b0;
    bif.bit4   = 1'b0;
    Rst        = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Rst        = 1'b1;
    bif.wr     = 1'b0;
    bif.DB     = '0;
    bif.bit4   = 1'b0;
    bif.out_en = 1'b0;

    // Reset state
    op(0, 8'h00, 0, 0, 1);
    chk("rst_count", 32'(bif.count), 32'd0);
    chk("rst_empty", 32'(bif.empty), 32'd1);
    chk("rst_full", 32'(bif.full), 32'd0);
    chk("rst_out", 32'(bif.out), 32'd0);
    chk("rst_vld", 32'(bif.out_vld), 32'd0);

    // Full byte A5 then two reads
    op(1, 8'hA5, 0, 0, 0);
    chk("a5_count", 32'(bif.count), 32'd8);
    chk("a5_empty", 32'(bif.empty), 32'd0);
    chk("a5_vld", 32'(bif.out_vld), 32'd0);
    op(0, 8'h00, 0, 1, 0);
    chk("rd1_out", 32'(bif.out), 32'b101);
    chk("rd1_vld", 32'(bif.out_vld), 32'd1);
    chk("rd1_count", 32'(bif.count), 32'd5);
    op(0, 8'h00, 0, 1, 0);
    chk("rd2_out", 32'(bif.out), 32'b100);
    chk("rd2_vld", 32'(bif.out_vld), 32'd1);
    chk("rd2_count", 32'(bif.count), 32'd2);
    chk("rd2_empty", 32'(bif.empty), 32'd1);
    // Read with only 2 bits stored is rejected; out holds
    op(0, 8'h00, 0, 1, 0);
    chk("rej_vld", 32'(bif.out_vld), 32'd0);
    chk("rej_out", 32'(bif.out), 32'b100);
    chk("rej_count", 32'(bif.count), 32'd2);
`ifdef BIT_FIFO_ERR_EN
    chk("rej_udf", 32'(bif.udf), 32'd1);
    chk("rej_ovf", 32'(bif.ovf), 32'd0);
`endif

    // Half-word write of 3C stores nibble C only
    op(0, 8'h00, 0, 0, 1);
    op(1, 8'h3C, 1, 0, 0);
    chk("nib_count", 32'(bif.count), 32'd4);
    op(0, 8'h00, 0, 1, 0);
    chk("nib_count2", 32'(bif.count), 32'd1);
    chk("nib_out", 32'(bif.out), 32'b100);

    // Fill to 512 bits; byte 0 is 5A
    op(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 64; i++) op(1, 8'(i) ^ 8'h5A, 0, 0, 0);
    chk("fill_count", 32'(bif.count), 32'd512);
    chk("fill_full", 32'(bif.full), 32'd1);
    op(1, 8'hFF, 0, 0, 0);
    chk("ovf_count", 32'(bif.count), 32'd512);
`ifdef BIT_FIFO_ERR_EN
    chk("ovf_flag", 32'(bif.ovf), 32'd1);
`endif
    // Simultaneous at full: read wins, write rejected
    op(1, 8'hFF, 0, 1, 0);
    chk("sim_count", 32'(bif.count), 32'd509);
    chk("sim_out", 32'(bif.out), 32'b010);
    chk("sim_vld", 32'(bif.out_vld), 32'd1);
    chk("sim_full", 32'(bif.full), 32'd1);

    // Wrap: wp=504, rp=504, then nibble 0 at 504..507 and FF at 508..511,0..3
    op(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 63; i++) op(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 168; i++) op(0, 8'h00, 0, 1, 0);
    chk("drain_count", 32'(bif.count), 32'd0);
    op(1, 8'hF0, 1, 0, 0);
    op(0, 8'h00, 0, 1, 0);
    chk("wr0_out", 32'(bif.out), 32'b000);
    op(1, 8'hFF, 0, 0, 0);
    chk("wff_count", 32'(bif.count), 32'd9);
    op(0, 8'h00, 0, 1, 0);
    chk("wr1_out", 32'(bif.out), 32'b110);
    op(0, 8'h00, 0, 1, 0);
    chk("wrap_out", 32'(bif.out), 32'b111);
    chk("wrap_count", 32'(bif.count), 32'd3);
    // Non-full simultaneous write/read: 3 + 8 - 3, reads addresses 1..3
    op(1, 8'h00, 0, 1, 0);
    chk("rw_count", 32'(bif.count), 32'd8);
    chk("rw_out", 32'(bif.out), 32'b111);

    // Reset priority at count 100 with concurrent requests
    op(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) op(1, 8'h33, 0, 0, 0);
    op(1, 8'h0F, 1, 0, 0);
    chk("c100_count", 32'(bif.count), 32'd100);
    op(0, 8'h00, 0, 1, 0);
    op(1, 8'hFF, 0, 1, 1);
    chk("rp_count", 32'(bif.count), 32'd0);
    chk("rp_empty", 32'(bif.empty), 32'd1);
    chk("rp_vld", 32'(bif.out_vld), 32'd0);
    chk("rp_out", 32'(bif.out), 32'd0);
`ifdef BIT_FIFO_ERR_EN
    chk("rp_ovf", 32'(bif.ovf), 32'd0);
    chk("rp_udf", 32'(bif.udf), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_fifo.md
BIT_FIFO -- requirements
Module: bit_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning storage size in bits (power of two, at least 16).
REQ-002 SHALL have parameter WR_W, default 8, meaning full write word width in bits (even, at most DEPTH).
REQ-003 SHALL have parameter RD_W, default 3, meaning read word width in bits (at most DEPTH).
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr, input, 1 bit: write request, active-high.
REQ-007 SHALL have port DB, input, WR_W bits: write data, bit 0 stored first.
REQ-008 SHALL have port bit4, input, 1 bit: half-word mode; when high, only DB[WR_W/2-1:0] is written.
REQ-009 SHALL have port out_en, input, 1 bit: read request, active-high.
REQ-010 SHALL have port out, output, RD_W bits: read data, bit 0 is the oldest bit.
REQ-011 SHALL have port out_vld, output, 1 bit: out updated by the previous cycle's accepted read.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits: number of stored bits.
REQ-013 SHALL have ports full and empty, outputs, 1 bit each: full means free space is less than WR_W; empty means count is less than RD_W.

Function
REQ-014 SHALL be a circular bit buffer with write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 SHALL set the write size n to WR_W/2 when bit4=1 and to WR_W when bit4=0.
REQ-016 SHALL accept a write when wr=1 and (DEPTH-count) is at least n, both evaluated before the edge.
REQ-017 SHALL, on an accepted write, store DB[k] at address (wp+k) mod DEPTH for k=0..n-1 and advance wp by n.
REQ-018 SHALL accept a read when out_en=1 and count is at least RD_W, evaluated before the edge.
REQ-019 SHALL, on an accepted read, register bit (rp+k) mod DEPTH into out[k] for k=0..RD_W-1, advance rp by RD_W, and set out_vld=1 for exactly the next cycle.
REQ-020 SHALL hold out at its last value when no read is accepted, and drive out_vld=0 in that case.
REQ-021 SHALL, on a simultaneous write and read, evaluate each against the pre-edge count; freed read space SHALL NOT enable a write in the same cycle.
REQ-022 SHALL update count as count + (n if write accepted) - (RD_W if read accepted), exact with no saturation.
REQ-023 SHALL derive full and empty combinationally from count.
REQ-024 SHALL ignore rejected requests, leaving memory, pointers and count unchanged.
REQ-025 SHALL allow reads to wrap across address DEPTH-1 to 0 within a single word.

Reset
REQ-026 SHALL, on Rst=1 at a rising edge, clear wp, rp, count, out and out_vld to 0, giving empty=1 and full=0.
REQ-027 SHALL give Rst priority over concurrent wr and out_en; data from a request in the reset cycle SHALL be discarded.
REQ-028 SHALL NOT clear storage contents on reset; stale bits are unreachable until they are rewritten.

Configuration
REQ-029 SHALL, with macro BIT_FIFO_ERR_EN defined, add 1-bit outputs ovf and udf.
REQ-030 SHALL set ovf when a write is rejected and udf when a read is rejected; both are sticky until Rst.
REQ-031 SHALL, without BIT_FIFO_ERR_EN, omit ovf and udf and silently drop rejected requests.

Verification (DEPTH=512, WR_W=8, RD_W=3)
REQ-032 SHALL cover: reset, write DB=8'hA5 with bit4=0, then two reads -> out=3'b101 then 3'b100, out_vld pulses, count 8 -> 5 -> 2, empty=1 at count 2.
REQ-033 SHALL cover: write DB=8'h3C with bit4=1, then read -> count 4 then 1, out=3'b100.
REQ-034 SHALL cover: 64 full-byte writes -> count=512, full=1; a 65th write is rejected, count stays 512, and ovf=1 when BIT_FIFO_ERR_EN is defined.
REQ-035 SHALL cover: at count=512, wr=1 and out_en=1 together -> read accepted, write rejected, count=509.
REQ-036 SHALL cover: advance pointers to wp=rp=510, write 8'hFF, read -> out=3'b111 spanning addresses 510, 511, 0, and count=5.
REQ-037 SHALL cover: Rst=1 asserted with wr=1 and count=100 -> next cycle count=0, empty=1, out_vld=0, ovf and udf=0.
